// File: rtl/nvdla_matrix_streamer.sv
// nvdla_matrix_streamer
// Reads a row-major 16-bit fixed-point matrix from SRAM (one 128-bit word per
// beat) and streams it as 8-lane beats on a valid/ready producer port. A small
// output FIFO with a credit check absorbs the one-cycle SRAM read latency.
// Lanes past the end of a row are zeroed in the last beat of every row.
module nvdla_matrix_streamer #(
   parameter int MAX_DIM    = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] row_stride,
   input  logic [31:0]       rows,
   input  logic [31:0]       cols,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [127:0]      mem_rd_data,
   output logic              out_valid,
   output logic [31:0]       out_addr,
   output logic [127:0]      out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE, S_ERROR
   } state_t;

   state_t            r_state;
   logic              r_busy, r_done, r_error;
   logic [ADDR_W-1:0] r_base, r_stride, r_row_addr;
   logic [31:0]       r_rows, r_cols, r_bpr, r_row, r_beat, r_elem_base;

   // Read in flight: its beat address and how many lanes carry real elements
   logic              r_inflight;
   logic [31:0]       r_inf_addr;
   logic [3:0]        r_inf_lanes;

   logic [127:0]      r_fifo_data [FIFO_DEPTH];
   logic [31:0]       r_fifo_addr [FIFO_DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              w_pop, w_push, w_rd_en, w_credit_ok, w_last_beat, w_last_row;
   logic [CW:0]       w_occ;
   logic [3:0]        w_lanes;
   logic [127:0]      w_push_data;

   assign w_pop       = (r_count != '0) && out_ready;
   assign w_push      = r_inflight;
   assign w_occ       = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
   assign w_credit_ok = w_occ < (CW+1)'(FIFO_DEPTH);
   assign w_rd_en     = (r_state == S_RUN) && w_credit_ok;
   assign w_last_beat = (r_beat == r_bpr - 32'd1);
   assign w_last_row  = (r_row == r_rows - 32'd1);
   assign w_lanes     = (w_last_beat && r_cols[2:0] != 3'd0) ? {1'b0, r_cols[2:0]} : 4'd8;

   assign mem_rd_en   = w_rd_en;
   assign mem_rd_addr = w_rd_en ? (r_row_addr + ADDR_W'(r_beat)) : '0;
   assign out_valid   = (r_count != '0);
   assign out_data    = out_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign out_addr    = out_valid ? r_fifo_addr[r_rd_ptr] : '0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;

   // Zero the lanes beyond the row end as the returning word enters the FIFO
   always_comb begin
      // NOTE: every combinationally-assigned variable gets a default first so no latch is inferred.
      w_push_data = mem_rd_data;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) >= r_inf_lanes) w_push_data[i*16 +: 16] = 16'h0000;
      end
   end

   // Control FSM: config latch, validation, read sequencing and completion
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_base      <= '0;
         r_stride    <= '0;
         r_rows      <= '0;
         r_cols      <= '0;
         r_bpr       <= '0;
         r_row       <= '0;
         r_beat      <= '0;
         r_row_addr  <= '0;
         r_elem_base <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_base   <= base_addr;
                  r_stride <= row_stride;
                  r_rows   <= rows;
                  r_cols   <= cols;
                  r_error  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (r_rows == '0 || r_cols == '0 ||
                   r_rows > 32'(MAX_DIM) || r_cols > 32'(MAX_DIM)) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_ERROR;
               end else begin
                  r_bpr       <= (r_cols + 32'd7) >> 3;
                  r_row       <= '0;
                  r_beat      <= '0;
                  r_row_addr  <= r_base;
                  r_elem_base <= '0;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_rd_en) begin
                  if (w_last_beat) begin
                     r_beat <= '0;
                     if (w_last_row) begin
                        r_state <= S_DRAIN;
                     end else begin
                        r_row       <= r_row + 32'd1;
                        r_row_addr  <= r_row_addr + r_stride;
                        r_elem_base <= r_elem_base + r_cols;
                     end
                  end else begin
                     r_beat <= r_beat + 32'd1;
                  end
               end
            end
            S_DRAIN: begin
               // Finish on the cycle the final beat leaves so done follows it by one cycle
               if (!r_inflight && (r_count == '0 || (r_count == CW'(1) && w_pop))) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_ERROR: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Track the outstanding read and the FIFO pointers/occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight  <= 1'b0;
         r_inf_addr  <= '0;
         r_inf_lanes <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_rd_en) begin
            r_inf_addr  <= r_elem_base + {r_beat[28:0], 3'b000};
            r_inf_lanes <= w_lanes;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage write port
   always_ff @(posedge clk) begin
      // NOTE: storage is left unreset; occupancy gates every read of it, so reset need only clear the count.
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= w_push_data;
         r_fifo_addr[r_wr_ptr] <= r_inf_addr;
      end
   end

endmodule
